// File: rtl/line_stream_reader.sv
// Collects 64 processed datapath lines into a local buffer, then streams them out in index order over valid/ready.
// Optional macro LINE_STREAM_CHECKSUM_EN appends an XOR checksum trailer beat to each block.
module line_stream_reader #(
  parameter int LINE_W = 25,
  parameter int DEPTH  = 64,
  parameter int IDX_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic [IDX_W-1:0]  cap_idx,
  input  logic [LINE_W-1:0] cap_line,
  input  logic              start,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [LINE_W-1:0] out_line,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              cap_err
);

  typedef enum logic [1:0] {IDLE, STREAM, FINISH} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  state_t            state;
  logic [LINE_W-1:0] buffer [DEPTH];
  logic [LINE_W-1:0] first_line;
  logic [IDX_W-1:0]  next_idx;
  logic              handshake;
  logic              write_ok;

`ifdef LINE_STREAM_CHECKSUM_EN
  logic [LINE_W-1:0] csum;
  logic              trailer;
`endif

  assign busy      = (state != IDLE);
  assign handshake = out_valid & out_ready;
  assign next_idx  = out_idx + IDX_W'(1);
  assign write_ok  = cap_en && (state != STREAM);

  // A capture to line 0 in the start cycle must be visible on the first beat.
  assign first_line = (cap_en && cap_idx == '0) ? cap_line : buffer[0];

  // Buffer is deliberately left out of reset so an aborted block can be replayed.
  always_ff @(posedge clk) begin
    if (write_ok)
      buffer[cap_idx] <= cap_line;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_line  <= '0;
      out_idx   <= '0;
      out_last  <= 1'b0;
      done      <= 1'b0;
      cap_err   <= 1'b0;
`ifdef LINE_STREAM_CHECKSUM_EN
      csum      <= '0;
      trailer   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state     <= STREAM;
            out_valid <= 1'b1;
            out_idx   <= '0;
            out_line  <= first_line;
            out_last  <= 1'b0;
            cap_err   <= 1'b0;
`ifdef LINE_STREAM_CHECKSUM_EN
            csum      <= '0;
            trailer   <= 1'b0;
`endif
          end
        end
        STREAM: begin
          if (cap_en)
            cap_err <= 1'b1;
          if (handshake) begin
`ifdef LINE_STREAM_CHECKSUM_EN
            if (trailer) begin
              state     <= FINISH;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              trailer   <= 1'b0;
              done      <= 1'b1;
            end else if (out_idx == LAST_IDX) begin
              out_line <= csum ^ out_line;
              out_idx  <= '0;
              out_last <= 1'b1;
              trailer  <= 1'b1;
            end else begin
              csum     <= csum ^ out_line;
              out_idx  <= next_idx;
              out_line <= buffer[next_idx];
            end
`else
            if (out_idx == LAST_IDX) begin
              state     <= FINISH;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              out_idx  <= next_idx;
              out_line <= buffer[next_idx];
              out_last <= (next_idx == LAST_IDX);
            end
`endif
          end
        end
        FINISH: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_stream_reader.sv
// Directed self-checking bench for line_stream_reader; honours LINE_STREAM_CHECKSUM_EN for the beat count and trailer.
module tb_line_stream_reader;

  localparam int LINE_W = 25;
  localparam int DEPTH  = 64;
  localparam int IDX_W  = 6;
`ifdef LINE_STREAM_CHECKSUM_EN
  localparam int BEATS = DEPTH + 1;
`else
  localparam int BEATS = DEPTH;
`endif
  localparam int LAST_BEAT = BEATS - 1;

  logic              clk;
  logic              rst;
  logic              cap_en;
  logic [IDX_W-1:0]  cap_idx;
  logic [LINE_W-1:0] cap_line;
  logic              start;
  logic              out_ready;
  logic              out_valid;
  logic [LINE_W-1:0] out_line;
  logic [IDX_W-1:0]  out_idx;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              cap_err;

  int vec_count  = 0;
  int miss_count = 0;

  logic [LINE_W-1:0] model [DEPTH];
  logic [LINE_W-1:0] last_trailer;

  typedef struct {
    logic             start;
    logic             ready;
    logic             exp_valid;
    logic [IDX_W-1:0] exp_idx;
    logic             exp_busy;
  } vec_t;

  vec_t vecs [9];

  line_stream_reader #(.LINE_W(LINE_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .cap_en(cap_en), .cap_idx(cap_idx), .cap_line(cap_line),
    .start(start), .out_ready(out_ready), .out_valid(out_valid), .out_line(out_line),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done), .cap_err(cap_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    start     = v.start;
    out_ready = v.ready;
    tick();
    start = 1'b0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 0);
    checkOutput({tag, " out_line"},  32'(out_line),  0);
    checkOutput({tag, " out_idx"},   32'(out_idx),   0);
    checkOutput({tag, " out_last"},  32'(out_last),  0);
    checkOutput({tag, " busy"},      32'(busy),      0);
    checkOutput({tag, " done"},      32'(done),      0);
    checkOutput({tag, " cap_err"},   32'(cap_err),   0);
  endtask

  function automatic logic [LINE_W-1:0] modelXor();
    logic [LINE_W-1:0] x = '0;
    for (int i = 0; i < DEPTH; i++) x ^= model[i];
    return x;
  endfunction

  // mode 0: ready always high; mode 1: ready pattern; mode 2: ready high plus a capture pulse on beat 3
  task automatic streamCheck(input int first_beat, input int mode, output int cycles);
    int   beat     = first_beat;
    int   cyc      = 0;
    bit   finished = 0;
    logic rdy;
    logic [LINE_W-1:0] exp_line;
    int   exp_idx;
    bit   pulsed;
    while (!finished && cyc < 1000) begin
      if (done) begin
        finished = 1;
      end else begin
        rdy = (mode == 1) ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
        out_ready = rdy;
        pulsed = (mode == 2) && out_valid && (out_idx == 3) && (beat == 3);
        cap_en   = pulsed;
        cap_idx  = 6'd5;
        cap_line = 25'h1FFFFFF;
        checkOutput("stream out_valid", 32'(out_valid), 1);
        checkOutput("stream busy", 32'(busy), 1);
        if (out_valid && rdy) begin
          if (beat >= BEATS) begin
            checkOutput("extra beat", 32'(beat), BEATS - 1);
          end else begin
            exp_line = (beat == DEPTH) ? modelXor() : model[beat];
            exp_idx  = (beat == DEPTH) ? 0 : beat;
            if (beat == DEPTH) last_trailer = out_line;
            checkOutput($sformatf("beat %0d out_idx", beat), 32'(out_idx), 32'(exp_idx));
            checkOutput($sformatf("beat %0d out_line", beat), 32'(out_line), 32'(exp_line));
            checkOutput($sformatf("beat %0d out_last", beat), 32'(out_last), 32'(beat == LAST_BEAT));
          end
          beat++;
        end
        tick();
        cyc++;
        cap_en = 1'b0;
        if (pulsed) checkOutput("cap_err after capture in stream", 32'(cap_err), 1);
      end
    end
    if (!finished) checkOutput("stream timeout waiting for done", 0, 1);
    checkOutput("handshake total", 32'(beat), 32'(BEATS));
    checkOutput("finish done", 32'(done), 1);
    checkOutput("finish busy", 32'(busy), 1);
    checkOutput("finish out_valid", 32'(out_valid), 0);
    checkOutput("finish out_last", 32'(out_last), 0);
    out_ready = 1'b0;
    tick();
    checkOutput("post done", 32'(done), 0);
    checkOutput("post busy", 32'(busy), 0);
    cycles = cyc;
  endtask

  task automatic startStream(input logic ready);
    start     = 1'b1;
    out_ready = ready;
    tick();
    start = 1'b0;
    checkOutput("first beat out_valid", 32'(out_valid), 1);
    checkOutput("first beat out_idx", 32'(out_idx), 0);
    checkOutput("first beat cap_err", 32'(cap_err), 0);
  endtask

  task automatic captureAll(input int kind);
    for (int i = 0; i < DEPTH; i++) begin
      cap_en   = 1'b1;
      cap_idx  = IDX_W'(i);
      cap_line = (kind == 0) ? LINE_W'(i * 32'h0001_0203) : ((i == 7) ? 25'h0000003 : 25'h0000001);
      model[i] = cap_line;
      tick();
    end
    cap_en = 1'b0;
  endtask

  initial begin
    int cycles;
    int guard;
    vecs[0] = '{1'b1, 1'b0, 1'b1, 6'd0, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 6'd1, 1'b1};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 6'd1, 1'b1};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 6'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 6'd2, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 6'd3, 1'b1};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 6'd3, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 6'd3, 1'b1};
    vecs[8] = '{1'b0, 1'b1, 1'b1, 6'd4, 1'b1};

    rst = 1'b1; cap_en = 1'b0; cap_idx = '0; cap_line = '0; start = 1'b0; out_ready = 1'b0;
    last_trailer = '0;
    #1 rst = 1'b0;
    repeat (3) tick();
    checkAllZero("in reset");
    rst = 1'b1;
    tick();
    checkAllZero("after reset");

    $display("[TB] capture and full-rate stream");
    captureAll(0);
    checkOutput("idle after capture busy", 32'(busy), 0);
    startStream(1'b1);
    streamCheck(0, 0, cycles);
    checkOutput("full-rate cycle count", 32'(cycles), 32'(BEATS));

    $display("[TB] backpressure");
    foreach (vecs[k]) begin
      applyStimulus(vecs[k]);
      checkOutput($sformatf("vec %0d out_valid", k), 32'(out_valid), 32'(vecs[k].exp_valid));
      checkOutput($sformatf("vec %0d out_idx", k), 32'(out_idx), 32'(vecs[k].exp_idx));
      checkOutput($sformatf("vec %0d out_line", k), 32'(out_line), 32'(model[vecs[k].exp_idx]));
      checkOutput($sformatf("vec %0d busy", k), 32'(busy), 32'(vecs[k].exp_busy));
      checkOutput($sformatf("vec %0d done", k), 32'(done), 0);
      checkOutput($sformatf("vec %0d out_last", k), 32'(out_last), 0);
    end
    streamCheck(4, 1, cycles);

    $display("[TB] capture during stream");
    startStream(1'b1);
    streamCheck(0, 2, cycles);
    checkOutput("cap_err sticky in idle", 32'(cap_err), 1);

    $display("[TB] same-cycle capture and start");
    cap_en = 1'b1; cap_idx = '0; cap_line = 25'h00ABCDE;
    model[0] = 25'h00ABCDE;
    start = 1'b1; out_ready = 1'b0;
    tick();
    cap_en = 1'b0; start = 1'b0;
    checkOutput("same-cycle first out_line", 32'(out_line), 32'h00ABCDE);
    checkOutput("same-cycle cap_err cleared", 32'(cap_err), 0);
    streamCheck(0, 0, cycles);

    $display("[TB] abort mid-stream");
    startStream(1'b1);
    guard = 0;
    while (out_idx != 6'd20 && guard < 100) begin
      out_ready = 1'b1;
      tick();
      guard++;
    end
    checkOutput("reached line 20", 32'(out_idx), 20);
    rst = 1'b0;
    #1;
    checkAllZero("async abort");
    tick();
    rst = 1'b1;
    out_ready = 1'b0;
    tick();
    checkOutput("no done after abort", 32'(done), 0);
    checkOutput("idle after abort", 32'(busy), 0);
    startStream(1'b0);
    checkOutput("restart line 0", 32'(out_line), 32'(model[0]));
    streamCheck(0, 0, cycles);

    $display("[TB] checksum pattern");
    captureAll(1);
    startStream(1'b1);
    streamCheck(0, 0, cycles);
`ifdef LINE_STREAM_CHECKSUM_EN
    checkOutput("checksum trailer", 32'(last_trailer), 32'h0000002);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
